// File: rtl/gray_seq_gen.sv
// rtl/gray_seq_gen.sv - registered reflected Gray-code sequence generator with valid/ready output
// Up/down counting with wrap, binary preload and a terminal-count flag registered with each word.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             READY,
  output logic [WIDTH-1:0] GRAY,
  output logic [WIDTH-1:0] BIN,
  output logic             VALID,
  output logic             TC
);

  typedef enum logic [1:0] {
    ST_PRIMED = 2'd0,
    ST_EMPTY  = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] next_cnt;
  logic             adv;
  logic             xfer;

  assign adv  = EN & ~LOAD & (~VALID | READY);
  assign xfer = VALID & READY;

  // A primed counter emits its own value first so a preload is never skipped.
  always_comb begin
    next_cnt = cnt;
    if (state != ST_PRIMED) begin
      if (UP) next_cnt = cnt + WIDTH'(1);
      else    next_cnt = cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_PRIMED;
      cnt   <= '0;
      GRAY  <= '0;
      BIN   <= '0;
      VALID <= 1'b0;
      TC    <= 1'b0;
    end else if (LOAD) begin
      // Load discards any pending word; the output bus keeps its last value.
      state <= ST_PRIMED;
      cnt   <= LOAD_VAL;
      VALID <= 1'b0;
    end else if (adv) begin
      state <= ST_FULL;
      cnt   <= next_cnt;
      BIN   <= next_cnt;
      GRAY  <= next_cnt ^ (next_cnt >> 1);
      TC    <= UP ? (&next_cnt) : ~(|next_cnt);
      VALID <= 1'b1;
    end else if (xfer) begin
      state <= ST_EMPTY;
      VALID <= 1'b0;
    end
  end

endmodule

// File: doc/gray_seq_gen.md
# gray_seq_gen

Registered Gray-code sequence generator. It directly feeds the combinational `gray_binary_mpc` Gray-to-binary converter. It emits one WIDTH-bit reflected Gray word per accepted transfer, counting up or down with wrap-around, and supports a binary preload. It uses a valid/ready handshake so the downstream stage can stall it. A companion binary output carries the expected decode of each emitted word, so benches can check the converter end to end.

## Interface
- `WIDTH`, default 4: code width in bits. Minimum 2.
- `clk`  in  1: rising-edge clock. Single clock domain.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `EN`  in  1: allows generation of the next word.
- `UP`  in  1: direction. 1 = increment, 0 = decrement. Sampled when a word is generated.
- `LOAD`  in  1: synchronous preload strobe. Has priority over `EN`.
- `LOAD_VAL`  in  WIDTH: binary start value applied on `LOAD`.
- `READY`  in  1: downstream accepts the current word.
- `GRAY`  out  WIDTH: registered Gray word, `BIN ^ (BIN >> 1)`.
- `BIN`  out  WIDTH: registered binary value that `GRAY` encodes.
- `VALID`  out  1: `GRAY`/`BIN` hold a word not yet accepted.
- `TC`  out  1: terminal count. Registered with the word. High when the emitted word is the last one in the current direction: `BIN` = 2^WIDTH-1 when `UP`=1, `BIN` = 0 when `UP`=0.

## Operation
- Internal binary register `CNT` holds the value of the last emitted (or primed) word. `BIN` mirrors `CNT` when a word is emitted.
- Transfer: `VALID` & `READY` in a cycle.
- Generate condition: `ADV = EN & !LOAD & (!VALID | READY)`.
- FSM, three states:
  - PRIMED (`VALID`=0). The next word generated is `CNT` itself. Entered on reset and on `LOAD`.
  - EMPTY (`VALID`=0). The next word generated is `CNT ± 1`.
  - FULL (`VALID`=1). `GRAY` = gray(`CNT`).
- Transitions:
  - PRIMED --`ADV`--> FULL. Emits gray(`CNT`); `CNT` unchanged.
  - EMPTY --`ADV`--> FULL. `CNT` <= `CNT` + 1 if `UP`, else `CNT` - 1, modulo 2^WIDTH. Emits the new value.
  - FULL --`ADV`--> FULL. Same as EMPTY: the current word is accepted and the next word is emitted in the same edge.
  - FULL --transfer & !`EN` & !`LOAD`--> EMPTY.
  - Any state --`LOAD`--> PRIMED. `CNT` <= `LOAD_VAL`. `VALID` <= 0, even if a word is pending (the pending word is discarded).
- Direction may change between any two generated words without skipping a value. After emitting 5 up, switching `UP`=0 makes the next word 4.
- Wrap-around: up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1. No stall and no flag other than `TC`.
- `EN`=0 in FULL with `READY`=0: the word holds.

## Timing
- Reset (async, `rst_n`=0): `CNT`=0, `GRAY`=0, `BIN`=0, `VALID`=0, `TC`=0, state PRIMED. Outputs change immediately without waiting for a clock.
- Reset release: synchronous use starts at the first rising edge with `rst_n`=1.
- Latency: `ADV` sampled high at edge n gives new `GRAY`/`BIN`/`TC`/`VALID` after edge n. One-cycle latency.
- Throughput: one word per cycle while `EN`=1 and `READY`=1.
- Stability: while `VALID`=1 and `READY`=0, `GRAY`, `BIN` and `TC` are stable.
- `LOAD` and transfer in the same cycle: the load wins. The word is considered accepted and `VALID` goes to 0.
- `LOAD` and `EN` in the same cycle: no word is generated. The first loaded word appears one cycle after a later `ADV`.
- Only the registered outputs drive the downstream converter. No combinational path from inputs to `GRAY`.

## Test plan
- Reset: hold `rst_n`=0 mid-run with `VALID`=1 → all outputs 0 asynchronously. After release with `EN`=1 and `READY`=1, the first word is `GRAY`=0000.
- Full up-count, WIDTH=4, `EN`=`UP`=`READY`=1 for 17 cycles → `GRAY` = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000. `TC`=1 only with 1000. `BIN` = 0..15, then 0.
- Backpressure: during the up-count, drop `READY` for 3 cycles while `GRAY`=0110 → `GRAY`=0110 and `VALID`=1 are held. After `READY`=1 the next word is 0111 with no skip.
- Load and down-count: `LOAD_VAL`=0011 with `LOAD`=1, then `UP`=0 → words 0010, 0011, 0001, 0000 (`TC`=1), then 1000 (wrap to 15).
- Direction change: up-count to `BIN`=5 (0111), set `UP`=0 → next words 0110, 0010.
- `LOAD` while FULL with `READY`=0 → `VALID` falls the next cycle and the pending word is never accepted. The next `ADV` emits gray(`LOAD_VAL`). Random stimulus: every accepted (`GRAY`, `BIN`) pair satisfies `GRAY` = `BIN ^ (BIN >> 1)`.
